// File: rtl/store_queue.sv
// Circular store queue: allocate at dispatch, fill at AGU writeback, commit from ROB,
// drain in order to the dcache. Flush discards only uncommitted entries.
module store_queue #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ROBID_W  = 7,
  parameter int unsigned PC_W     = 64,
  parameter int unsigned COMMIT_W = 2,
  localparam int unsigned IDX_W   = $clog2(DEPTH),
  localparam int unsigned PTR_W   = IDX_W + 1,
  localparam int unsigned CNT_W   = $clog2(COMMIT_W + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  logic [ROBID_W-1:0] enq_robid,
  input  logic [PC_W-1:0]    enq_pc,
  output logic [PTR_W-1:0]   enq_sqid,
  input  logic               wb_valid,
  input  logic [PTR_W-1:0]   wb_sqid,
  input  logic               wb_mmio,
  input  logic [DATA_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic [DATA_W-1:0]  wb_mask,
  input  logic [3:0]         wb_ls_size,
  input  logic [CNT_W-1:0]   commit_cnt,
  input  logic               flush,
  output logic               deq_valid,
  input  logic               deq_ready,
  output logic [DATA_W-1:0]  deq_addr,
  output logic [DATA_W-1:0]  deq_data,
  output logic [DATA_W-1:0]  deq_mask,
  output logic [3:0]         deq_ls_size,
  output logic               deq_mmio,
  output logic [ROBID_W-1:0] deq_robid,
  output logic [PTR_W-1:0]   count,
  output logic               empty,
  output logic               full
);

  logic [PTR_W-1:0]   head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [DEPTH-1:0]   valid_q, valid_d, wb_done_q, wb_done_d, mmio_q, mmio_d;
  logic [ROBID_W-1:0] robid_q [DEPTH];
  logic [ROBID_W-1:0] robid_d [DEPTH];
  logic [PC_W-1:0]    pc_q    [DEPTH];
  logic [PC_W-1:0]    pc_d    [DEPTH];
  logic [DATA_W-1:0]  addr_q  [DEPTH];
  logic [DATA_W-1:0]  addr_d  [DEPTH];
  logic [DATA_W-1:0]  data_q  [DEPTH];
  logic [DATA_W-1:0]  data_d  [DEPTH];
  logic [DATA_W-1:0]  mask_q  [DEPTH];
  logic [DATA_W-1:0]  mask_d  [DEPTH];
  logic [3:0]         size_q  [DEPTH];
  logic [3:0]         size_d  [DEPTH];

  logic               deq_valid_q, deq_valid_d, deq_mmio_q, deq_mmio_d;
  logic [DATA_W-1:0]  deq_addr_q, deq_addr_d, deq_data_q, deq_data_d, deq_mask_q, deq_mask_d;
  logic [3:0]         deq_size_q, deq_size_d;
  logic [ROBID_W-1:0] deq_robid_q, deq_robid_d;

  logic               deq_fire, enq_fire, wb_ok;
  logic [PTR_W-1:0]   occ, wb_off, room, flush_len;
  logic [IDX_W-1:0]   tidx, hidx, widx, nidx, off;

  assign full        = (head_q[IDX_W] != tail_q[IDX_W]) && (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
  assign empty       = (head_q == tail_q);
  assign enq_ready   = ~full;
  assign enq_sqid    = tail_q;
  assign count       = tail_q - head_q;
  assign deq_valid   = deq_valid_q;
  assign deq_addr    = deq_addr_q;
  assign deq_data    = deq_data_q;
  assign deq_mask    = deq_mask_q;
  assign deq_ls_size = deq_size_q;
  assign deq_mmio    = deq_mmio_q;
  assign deq_robid   = deq_robid_q;

  // Pointer and entry next-state; head outputs are registered from the next-state view
  always_comb begin
    occ       = tail_q - head_q;
    deq_fire  = deq_valid_q & deq_ready;
    enq_fire  = enq_valid & ~full & ~flush;
    tidx      = tail_q[IDX_W-1:0];
    hidx      = head_q[IDX_W-1:0];
    widx      = wb_sqid[IDX_W-1:0];
    wb_off    = wb_sqid - head_q;
    wb_ok     = wb_valid & ~flush & valid_q[widx] & (wb_off < occ)
                & ~(deq_fire & (wb_sqid == head_q));
    room      = tail_q - cmt_q;
    cmt_d     = (PTR_W'(commit_cnt) > room) ? tail_q : cmt_q + PTR_W'(commit_cnt);
    head_d    = head_q + PTR_W'(deq_fire);
    tail_d    = flush ? cmt_d : tail_q + PTR_W'(enq_fire);
    flush_len = tail_q - cmt_d;

    valid_d   = valid_q;
    wb_done_d = wb_done_q;
    mmio_d    = mmio_q;
    robid_d   = robid_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mask_d    = mask_q;
    size_d    = size_q;
    off       = '0;

    if (enq_fire) begin
      valid_d[tidx]   = 1'b1;
      wb_done_d[tidx] = 1'b0;
      mmio_d[tidx]    = 1'b0;
      robid_d[tidx]   = enq_robid;
      pc_d[tidx]      = enq_pc;
    end
    if (wb_ok) begin
      wb_done_d[widx] = 1'b1;
      mmio_d[widx]    = wb_mmio;
      addr_d[widx]    = wb_addr;
      data_d[widx]    = wb_data;
      mask_d[widx]    = wb_mask;
      size_d[widx]    = wb_ls_size;
    end
    if (deq_fire) begin
      valid_d[hidx]   = 1'b0;
      wb_done_d[hidx] = 1'b0;
    end
    // Flush kills every entry in [cmt_d, tail_q) in ring order
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        off = IDX_W'(i) - cmt_d[IDX_W-1:0];
        if ({1'b0, off} < flush_len) begin
          valid_d[i]   = 1'b0;
          wb_done_d[i] = 1'b0;
        end
      end
    end

    nidx        = head_d[IDX_W-1:0];
    deq_valid_d = (head_d != cmt_d) & wb_done_d[nidx];
    deq_mmio_d  = mmio_d[nidx];
    deq_addr_d  = addr_d[nidx];
    deq_data_d  = data_d[nidx];
    deq_mask_d  = mask_d[nidx];
    deq_size_d  = size_d[nidx];
    deq_robid_d = robid_d[nidx];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      cmt_q       <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      wb_done_q   <= '0;
      mmio_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        robid_q[i] <= '0;
        pc_q[i]    <= '0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        mask_q[i]  <= '0;
        size_q[i]  <= '0;
      end
      deq_valid_q <= 1'b0;
      deq_mmio_q  <= 1'b0;
      deq_addr_q  <= '0;
      deq_data_q  <= '0;
      deq_mask_q  <= '0;
      deq_size_q  <= '0;
      deq_robid_q <= '0;
    end else begin
      head_q      <= head_d;
      cmt_q       <= cmt_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      wb_done_q   <= wb_done_d;
      mmio_q      <= mmio_d;
      robid_q     <= robid_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      size_q      <= size_d;
      deq_valid_q <= deq_valid_d;
      deq_mmio_q  <= deq_mmio_d;
      deq_addr_q  <= deq_addr_d;
      deq_data_q  <= deq_data_d;
      deq_mask_q  <= deq_mask_d;
      deq_size_q  <= deq_size_d;
      deq_robid_q <= deq_robid_d;
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed lifecycle scenarios followed by random traffic,
// all checked against an unbounded-counter reference model of the queue.
module tb_store_queue;

  logic        clock, reset_n;
  logic        enq_valid, enq_ready;
  logic [6:0]  enq_robid;
  logic [63:0] enq_pc;
  logic [4:0]  enq_sqid;
  logic        wb_valid, wb_mmio;
  logic [4:0]  wb_sqid;
  logic [63:0] wb_addr, wb_data, wb_mask;
  logic [3:0]  wb_ls_size;
  logic [1:0]  commit_cnt;
  logic        flush;
  logic        deq_valid, deq_ready, deq_mmio;
  logic [63:0] deq_addr, deq_data, deq_mask;
  logic [3:0]  deq_ls_size;
  logic [6:0]  deq_robid;
  logic [4:0]  count;
  logic        empty, full;

  store_queue dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_robid(enq_robid), .enq_pc(enq_pc),
    .enq_sqid(enq_sqid),
    .wb_valid(wb_valid), .wb_sqid(wb_sqid), .wb_mmio(wb_mmio), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_mask(wb_mask), .wb_ls_size(wb_ls_size),
    .commit_cnt(commit_cnt), .flush(flush),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_addr(deq_addr), .deq_data(deq_data),
    .deq_mask(deq_mask), .deq_ls_size(deq_ls_size), .deq_mmio(deq_mmio), .deq_robid(deq_robid),
    .count(count), .empty(empty), .full(full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: head/commit/tail as unbounded store sequence numbers
  int          mh, mc, mt;
  bit          m_valid [16];
  bit          m_done  [16];
  bit          m_mmio  [16];
  logic [6:0]  m_robid [16];
  logic [63:0] m_addr  [16];
  logic [63:0] m_data  [16];
  logic [63:0] m_mask  [16];
  logic [3:0]  m_size  [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mc = 0; mt = 0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_done[i] = 0; m_mmio[i] = 0; m_robid[i] = '0;
      m_addr[i] = '0; m_data[i] = '0; m_mask[i] = '0; m_size[i] = '0;
    end
  endtask

  function automatic bit model_deq_valid();
    return (mh != mc) && m_done[mh % 16];
  endfunction

  task automatic check_all();
    int hi;
    hi = mh % 16;
    check("count", 64'(count), 64'(mt - mh));
    check("enq_sqid", 64'(enq_sqid), 64'(mt % 32));
    check("empty", 64'(empty), 64'(mt == mh));
    check("full", 64'(full), 64'((mt - mh) == 16));
    check("enq_ready", 64'(enq_ready), 64'((mt - mh) != 16));
    check("deq_valid", 64'(deq_valid), 64'(model_deq_valid()));
    if (model_deq_valid()) begin
      check("deq_robid", 64'(deq_robid), 64'(m_robid[hi]));
      check("deq_addr", deq_addr, m_addr[hi]);
      check("deq_data", deq_data, m_data[hi]);
      check("deq_mask", deq_mask, m_mask[hi]);
      check("deq_ls_size", 64'(deq_ls_size), 64'(m_size[hi]));
      check("deq_mmio", 64'(deq_mmio), 64'(m_mmio[hi]));
    end
  endtask

  task automatic idle();
    enq_valid = 0; enq_robid = '0; enq_pc = '0;
    wb_valid = 0; wb_sqid = '0; wb_mmio = 0; wb_addr = '0; wb_data = '0; wb_mask = '0;
    wb_ls_size = '0; commit_cnt = '0; flush = 0; deq_ready = 0;
  endtask

  // Apply current inputs for one clock, advance the model, then check
  task automatic tick();
    bit dfire, efire, found, wok;
    int pfound, cn, tn, hn, ws;
    dfire  = model_deq_valid() && deq_ready;
    efire  = enq_valid && ((mt - mh) != 16) && !flush;
    found  = 0;
    pfound = 0;
    for (int p = mh; p < mt; p++)
      if ((p % 32) == int'(wb_sqid)) begin found = 1; pfound = p; end
    ws  = int'(wb_sqid) % 16;
    wok = wb_valid && !flush && m_valid[ws] && found && !(dfire && pfound == mh);
    cn  = (mc + int'(commit_cnt) > mt) ? mt : mc + int'(commit_cnt);
    tn  = flush ? cn : mt + int'(efire);
    hn  = mh + int'(dfire);
    if (efire) begin
      m_valid[mt % 16] = 1; m_done[mt % 16] = 0; m_mmio[mt % 16] = 0;
      m_robid[mt % 16] = enq_robid;
    end
    if (wok) begin
      m_done[ws] = 1; m_mmio[ws] = wb_mmio; m_addr[ws] = wb_addr;
      m_data[ws] = wb_data; m_mask[ws] = wb_mask; m_size[ws] = wb_ls_size;
    end
    if (dfire) begin m_valid[mh % 16] = 0; m_done[mh % 16] = 0; end
    if (flush)
      for (int p = cn; p < mt; p++) begin m_valid[p % 16] = 0; m_done[p % 16] = 0; end
    @(posedge clock);
    #1;
    mh = hn; mc = cn; mt = tn;
    check_all();
  endtask

  task automatic check_reset_outputs();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_enq_sqid", 64'(enq_sqid), 64'd0);
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_deq_addr", deq_addr, 64'd0);
    check("rst_deq_data", deq_data, 64'd0);
    check("rst_deq_robid", 64'(deq_robid), 64'd0);
    check("rst_deq_mmio", 64'(deq_mmio), 64'd0);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    #2;
    model_reset();
    check_reset_outputs();
    @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  task automatic enq(input logic [6:0] rid);
    idle(); enq_valid = 1; enq_robid = rid; enq_pc = 64'h1000 + 64'(rid); tick();
  endtask

  task automatic wb(input logic [4:0] s, input logic mm, input logic [63:0] a, input logic [63:0] d,
                    input logic [1:0] cc, input logic dr);
    idle(); wb_valid = 1; wb_sqid = s; wb_mmio = mm; wb_addr = a; wb_data = d;
    wb_mask = 64'hFF; wb_ls_size = 4'd8; commit_cnt = cc; deq_ready = dr; tick();
  endtask

  logic [63:0] held_addr;
  logic [4:0]  s5;

  initial begin
    idle();
    reset_n = 1;
    #1;
    do_reset();

    // Three allocations get consecutive sqids
    for (int k = 0; k < 3; k++) begin
      check("t1_sqid", 64'(enq_sqid), 64'(k));
      enq(7'(5 + k));
    end
    check("t1_count", 64'(count), 64'd3);
    check("t1_deq_valid", 64'(deq_valid), 64'd0);

    // Committed head without writeback blocks draining
    wb(5'd1, 0, 64'h8000_1000, 64'hDEAD, 2'd2, 1);
    check("t2_blocked", 64'(deq_valid), 64'd0);
    idle(); deq_ready = 1; tick();
    check("t2_blocked2", 64'(deq_valid), 64'd0);
    wb(5'd0, 0, 64'h8000_0F00, 64'hBEEF, 2'd0, 1);
    check("t2_head0", 64'(deq_robid), 64'd5);
    idle(); deq_ready = 1; tick();
    check("t2_head1_robid", 64'(deq_robid), 64'd6);
    check("t2_head1_addr", deq_addr, 64'h8000_1000);
    check("t2_head1_data", deq_data, 64'hDEAD);
    idle(); deq_ready = 1; tick();
    check("t2_drained", 64'(deq_valid), 64'd0);

    // Fill to full, then deq+enq in one cycle; wrap sqid appears
    do_reset();
    for (int k = 0; k < 16; k++) enq(7'(k));
    check("t3_full", 64'(full), 64'd1);
    check("t3_enq_ready", 64'(enq_ready), 64'd0);
    check("t3_wrap_sqid", 64'(enq_sqid), 64'h10);
    wb(5'd0, 0, 64'h40, 64'h4, 2'd1, 0);
    idle(); deq_ready = 1; enq_valid = 1; enq_robid = 7'd99; tick();
    check("t3_count_after_deq", 64'(count), 64'd15);
    enq(7'd99);
    check("t3_count_refill", 64'(count), 64'd16);

    // Flush keeps committed entries plus this cycle's commit
    do_reset();
    for (int k = 0; k < 4; k++) enq(7'(20 + k));
    idle(); commit_cnt = 2; tick();
    idle(); flush = 1; commit_cnt = 1; enq_valid = 1; enq_robid = 7'd77; tick();
    check("t4_count", 64'(count), 64'd3);
    check("t4_tail", 64'(enq_sqid), 64'd3);
    for (int k = 0; k < 3; k++) wb(5'(k), 0, 64'(100 + k), 64'(k), 2'd0, 1);
    for (int k = 0; k < 3; k++) begin idle(); deq_ready = 1; tick(); end
    check("t4_empty", 64'(empty), 64'd1);

    // MMIO store held at head while dcache stalls
    s5 = enq_sqid;
    enq(7'd9);
    wb(s5, 1, 64'hF000_0040, 64'h55, 2'd1, 0);
    check("t5_mmio", 64'(deq_mmio), 64'd1);
    held_addr = deq_addr;
    for (int k = 0; k < 3; k++) begin
      idle(); tick();
      check("t5_hold_addr", deq_addr, 64'hF000_0040);
      check("t5_hold_valid", 64'(deq_valid), 64'd1);
    end
    check("t5_hold_snapshot", deq_addr, held_addr);
    idle(); deq_ready = 1; tick();

    // Asynchronous reset in the middle of a drain
    for (int k = 0; k < 4; k++) begin s5 = enq_sqid; enq(7'(40 + k)); wb(s5, 0, 64'(k), 64'(k), 2'd1, 1); end
    idle(); deq_ready = 1;
    do_reset();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      idle();
      enq_valid  = ($urandom % 2) != 0;
      enq_robid  = 7'($urandom);
      enq_pc     = {$urandom, $urandom};
      wb_valid   = ($urandom % 4) != 0;
      if (mt > mh && ($urandom % 8) != 0)
        wb_sqid = 5'((mh + int'($urandom_range(0, mt - mh - 1))) % 32);
      else
        wb_sqid = 5'($urandom);
      wb_mmio    = ($urandom % 4) == 0;
      wb_addr    = {$urandom, $urandom};
      wb_data    = {$urandom, $urandom};
      wb_mask    = {$urandom, $urandom};
      wb_ls_size = 4'($urandom);
      commit_cnt = 2'($urandom_range(0, 2));
      flush      = ($urandom % 24) == 0;
      deq_ready  = ($urandom % 4) != 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
